// File: rtl/sram_pkg.sv
// Shared scratchpad SRAM definitions: geometry, DMA state/mode types and
// the DMA command range check.
package sram_pkg;

    localparam int          SRAM_AW      = 13;
    localparam int          SRAM_DEPTH   = 2048;
    localparam int          DMA_LEN_W    = 12;
    localparam logic [3:0]  SRAM_BE_FULL = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_state_t;

    typedef enum logic {
        COPY = 1'b0,
        FILL = 1'b1
    } dma_mode_t;

    // True when a command would touch a misaligned word or run past the top
    // of the scratchpad. The source is only checked when it is actually read.
    function automatic logic dma_cmd_bad(
        input logic [SRAM_AW-1:0]   src,
        input logic [SRAM_AW-1:0]   dst,
        input logic [DMA_LEN_W-1:0] len,
        input logic                 chk_src
    );
        logic [SRAM_AW-1:0] src_end;
        logic [SRAM_AW-1:0] dst_end;
        logic               bad;
        src_end = SRAM_AW'(src[SRAM_AW-1:2]) + SRAM_AW'(len);
        dst_end = SRAM_AW'(dst[SRAM_AW-1:2]) + SRAM_AW'(len);
        bad = (dst[1:0] != 2'b00)
           || (len > DMA_LEN_W'(SRAM_DEPTH))
           || (dst_end > SRAM_AW'(SRAM_DEPTH));
        if (chk_src) begin
            bad = bad || (src[1:0] != 2'b00) || (src_end > SRAM_AW'(SRAM_DEPTH));
        end
        return bad;
    endfunction

endpackage

// File: rtl/sram_dma_engine.sv
// Scratchpad SRAM block-copy / pattern-fill DMA initiator.
// Optional feature macro: SRAM_DMA_FILL_EN (adds fill mode and fill_pattern).
module sram_dma_engine #(
    parameter int SRAM_AW = 13,
    parameter int LEN_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [SRAM_AW-1:0] src_addr,
    input  logic [SRAM_AW-1:0] dst_addr,
    input  logic [LEN_W-1:0]   len,
`ifdef SRAM_DMA_FILL_EN
    input  logic [31:0]        fill_pattern,
`endif
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LEN_W-1:0]   words_done,
    output logic               sram_req,
    output logic               sram_we,
    output logic [3:0]         sram_be,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    input  logic               sram_ready
);

    import sram_pkg::*;

`ifdef SRAM_DMA_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    dma_state_t         state, state_n;
    dma_mode_t          mode_q, mode_n;
    logic [SRAM_AW-1:0] src_q, src_n;
    logic [SRAM_AW-1:0] dst_q, dst_n;
    logic [LEN_W-1:0]   left_q, left_n;
    logic [LEN_W-1:0]   wcnt_n;
    logic               err_n;
    logic               reject;
    logic               cmd_fill;
    logic               cmd_bad;
    logic               fill_ld;
    logic               wr_copy_q;
    logic [31:0]        wdata_q;

    assign sram_be  = SRAM_BE_FULL;
    assign cmd_fill = mode;
    assign cmd_bad  = dma_cmd_bad(src_addr, dst_addr, len, !cmd_fill)
                   || (cmd_fill && !FILL_EN);

    // Next-state and datapath update; defaults hold every register.
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        src_n   = src_q;
        dst_n   = dst_q;
        left_n  = left_q;
        wcnt_n  = words_done;
        err_n   = err;
        reject  = 1'b0;
        fill_ld = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cmd_bad) begin
                        reject = 1'b1;
                        err_n  = 1'b1;
                    end else begin
                        err_n   = 1'b0;
                        wcnt_n  = '0;
                        mode_n  = cmd_fill ? FILL : COPY;
                        src_n   = src_addr;
                        dst_n   = dst_addr;
                        left_n  = len;
                        fill_ld = cmd_fill;
                        if (len == '0)    state_n = DONE;
                        else if (cmd_fill) state_n = WR;
                        else               state_n = RD;
                    end
                end
            end
            RD: begin
                if (abort)           state_n = DONE;
                else if (sram_ready) state_n = WR;
            end
            WR: begin
                if (sram_ready) begin
                    wcnt_n = words_done + LEN_W'(1);
                    src_n  = src_q + SRAM_AW'(4);
                    dst_n  = dst_q + SRAM_AW'(4);
                    left_n = left_q - LEN_W'(1);
                    if (left_q == LEN_W'(1) || abort) state_n = DONE;
                    else if (mode_q == FILL)           state_n = WR;
                    else                               state_n = RD;
                end else if (abort) begin
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered status / SRAM request outputs.
    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= COPY;
            src_q      <= '0;
            dst_q      <= '0;
            left_q     <= '0;
            words_done <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            wr_copy_q  <= 1'b0;
        end else begin
            state      <= state_n;
            mode_q     <= mode_n;
            src_q      <= src_n;
            dst_q      <= dst_n;
            left_q     <= left_n;
            words_done <= wcnt_n;
            err        <= err_n;
            done       <= reject || (state_n == DONE);
            busy       <= (state_n != IDLE);
            sram_req   <= (state_n == RD) || (state_n == WR);
            sram_we    <= (state_n == WR);
            if (state_n == RD)      sram_addr <= src_n;
            else if (state_n == WR) sram_addr <= dst_n;
            wr_copy_q  <= (state_n == WR) && (mode_n == COPY);
        end
    end

`ifdef SRAM_DMA_FILL_EN
    // Latch the fill pattern when a fill command is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       wdata_q <= '0;
        else if (fill_ld) wdata_q <= fill_pattern;
    end
`else
    assign wdata_q = '0;
`endif

    // Copy writes forward the read data straight through; it stays stable
    // because no further read is issued until the write is accepted.
    assign sram_wdata = wr_copy_q ? sram_rdata : wdata_q;

endmodule
